// File: rtl/hs32_execute3.sv
// HS32 stage-3 execute/writeback: ALU, NZCV flags, registered result, regfile write and forwarding.
// Optional iterative shift-add multiplier with back-pressure, compiled in with `HS32_MUL_EN.

package hs32_pkg;
    typedef struct packed {
        logic       neg;
        logic       sub;
        logic       cen;
        logic [1:0] opr;
        logic       fwe;
    } hs32_aluctl;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [3:0]  rd;
        logic        we1;
        logic        we2;
        hs32_aluctl  ctl;
    } hs32_s2pkt;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  rd;
        logic        we;
    } hs32_s3pkt;
endpackage

module hs32_execute3
    import hs32_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  hs32_s2pkt   data_i,
    input  logic        valid_i,
    output logic        ready_o,
`ifdef HS32_MUL_EN
    input  logic        mul_i,
`endif
    output hs32_s3pkt   data_o,
    output logic        valid_o,
    output logic [3:0]  rd3_o,
    output logic        stl3_o,
    output logic [3:0]  wp_addr_o,
    output logic [31:0] wp_data_o,
    output logic        wp_we_o,
    output logic [3:0]  flags_o
);
    localparam int FN = 3;
    localparam int FZ = 2;
    localparam int FC = 1;
    localparam int FV = 0;

    hs32_s3pkt   data_q, data_d;
    logic        valid_q, valid_d;
    logic [3:0]  flags_q, flags_d;
    logic        accept;
    logic        mul_req;

    logic [31:0] b;
    logic        cin;
    logic [32:0] sum;
    logic [31:0] alu_res;

    logic        unused_we2;
    assign unused_we2 = data_i.we2;

`ifdef HS32_MUL_EN
    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] acc_step;
    logic [3:0]  mrd_q, mrd_d;
    logic        mwe_q, mwe_d;
    logic        mfwe_q, mfwe_d;

    assign mul_req = mul_i;
    assign ready_o = rstn & (state_q == IDLE);
`else
    assign mul_req = 1'b0;
    assign ready_o = rstn;
`endif

    assign accept = valid_i & ready_o;

    always_comb begin
        b       = data_i.ctl.neg ? ~data_i.d2 : data_i.d2;
        cin     = data_i.ctl.cen ? flags_q[FC] : data_i.ctl.sub;
        sum     = {1'b0, data_i.d1} + {1'b0, b} + {32'd0, cin};
        case (data_i.ctl.opr)
            2'd0:    alu_res = sum[31:0];
            2'd1:    alu_res = data_i.d1 & b;
            2'd2:    alu_res = data_i.d1 | b;
            default: alu_res = data_i.d1 ^ b;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal is defaulted before any branch so no latch can be inferred.
        valid_d = 1'b0;
        data_d  = data_q;
        flags_d = flags_q;

        if (accept && !mul_req) begin
            data_d  = '{res: alu_res, rd: data_i.rd, we: data_i.we1};
            valid_d = 1'b1;
            if (data_i.ctl.fwe) begin
                flags_d[FN] = alu_res[31];
                flags_d[FZ] = (alu_res == 32'd0);
                if (data_i.ctl.opr == 2'd0) begin
                    flags_d[FC] = sum[32];
                    flags_d[FV] = (data_i.d1[31] == b[31]) & (alu_res[31] != data_i.d1[31]);
                end
            end
        end

`ifdef HS32_MUL_EN
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        mrd_d    = mrd_q;
        mwe_d    = mwe_q;
        mfwe_d   = mfwe_q;
        acc_step = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

        case (state_q)
            IDLE: begin
                if (accept && mul_req) begin
                    state_d  = MUL;
                    cnt_d    = 6'd0;
                    mcand_d  = data_i.d1;
                    mplier_d = data_i.d2;
                    acc_d    = 32'd0;
                    mrd_d    = data_i.rd;
                    mwe_d    = data_i.we1;
                    mfwe_d   = data_i.ctl.fwe;
                end
            end
            MUL: begin
                // Only the low 32 product bits are kept, so the multiplicand may shift out of range.
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                acc_d    = acc_step;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = IDLE;
                    cnt_d   = 6'd0;
                    data_d  = '{res: acc_step, rd: mrd_q, we: mwe_q};
                    valid_d = 1'b1;
                    if (mfwe_q) begin
                        flags_d[FN] = acc_step[31];
                        flags_d[FZ] = (acc_step == 32'd0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            flags_q <= 4'd0;
`ifdef HS32_MUL_EN
            state_q <= IDLE;
            cnt_q   <= 6'd0;
`endif
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            flags_q <= flags_d;
`ifdef HS32_MUL_EN
            state_q <= state_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

`ifdef HS32_MUL_EN
    // NOTE: multiplier datapath registers carry no reset; they are only consumed in MUL, which reset exits.
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
        mrd_q    <= mrd_d;
        mwe_q    <= mwe_d;
        mfwe_q   <= mfwe_d;
    end
`endif

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign rd3_o     = data_q.rd;
    assign stl3_o    = valid_q & data_q.we;
    assign wp_addr_o = data_q.rd;
    assign wp_data_o = data_q.res;
    assign wp_we_o   = valid_q & data_q.we;
    assign flags_o   = flags_q;

endmodule

// File: doc/hs32_execute3.md
# hs32_execute3

Stage-3 execute/writeback block of the HS32 core pipeline, the consumer of the `hs32_s2pkt` stream produced by stage-2 decode. It performs the ALU operation selected by `hs32_aluctl`, maintains the NZCV flags register and registers the result into an `hs32_s3pkt`. It writes that result back to the register file and drives `rd3`/`stl3` together with the forwarded result back to stage 2. An optional iterative multiplier adds a multi-cycle path with back-pressure.

## Interface
- No parameters.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rstn`  in  1  reset; synchronous, active-low.
- `data_i`  in  hs32_s2pkt  operands `d1`/`d2`, `rd`, `we1`, `we2`, `ctl` (`neg`, `sub`, `cen`, `opr[1:0]`, `fwe`).
- `valid_i`  in  1  `data_i` is valid this cycle.
- `ready_o`  out  1  stage 3 accepts `data_i` this cycle.
- `mul_i`  in  1  multiply request, qualified by `valid_i`; port exists only with `HS32_MUL_EN`.
- `data_o`  out  hs32_s3pkt  `res[31:0]` is the registered result, also the forwarding source; `rd`; `we`.
- `valid_o`  out  1  `data_o` holds a fresh result this cycle.
- `rd3_o`  out  4  destination register of the held result (`data_o.rd`).
- `stl3_o`  out  1  held result is forwardable: `valid_o & data_o.we`.
- `wp_addr_o`  out  4  regfile write address, equal to `data_o.rd`.
- `wp_data_o`  out  32  regfile write data, equal to `data_o.res`.
- `wp_we_o`  out  1  regfile write enable, equal to `valid_o & data_o.we`.
- `flags_o`  out  4  NZCV flags register, {N,Z,C,V}.

## Operation
- Accept: `valid_i & ready_o` at a rising edge.
- Operand preparation: `b = ctl.neg ? ~d2 : d2`. Carry-in is `ctl.sub` if `ctl.cen` = 0, else the current `flags_o.C`.
- `opr` selects the operation:
  - 0: `d1 + b + cin`, computed 33 bits wide.
  - 1: `d1 & b`.
  - 2: `d1 | b`.
  - 3: `d1 ^ b`.
- Flags update only when `ctl.fwe` = 1:
  - N = `res[31]`.
  - Z = (`res` == 0).
  - For `opr` 0: C = bit 32 of the sum, and V = (`d1[31]` == `b[31]`) & (`res[31]` != `d1[31]`).
  - For `opr` 1–3: C and V are unchanged.
- Accepted op: `data_o.res`, `rd` and `we` (= `data_i.we1`) load, and `valid_o` = 1 for exactly one cycle. With no accept, `valid_o` returns to 0 and `data_o` holds its value.
- `we2` is ignored.
- FSM has two states, IDLE and MUL (MUL exists only with the macro):
  - IDLE: `ready_o` = 1.
  - IDLE → MUL on an accept with `mul_i` = 1.
  - MUL: `ready_o` = 0; shift-add runs 1 bit per cycle for 32 cycles on a 6-bit counter.
  - MUL → IDLE when the counter reaches 31; the low 32 bits of the product are loaded into `data_o` and `valid_o` = 1.
- Multiply flags: N and Z update if `fwe`; C and V are unchanged.
- Reset (`rstn` = 0 at an edge), including during MUL:
  - FSM → IDLE, counter = 0.
  - `valid_o`, `stl3_o`, `wp_we_o` = 0.
  - `data_o` = all zero, `rd3_o` = 0.
  - `flags_o` = 0.
  - `ready_o` = 1 from the cycle after reset.
  - An in-flight multiply is discarded.

## Timing
- ALU latency is 1: an op accepted at edge N is visible on `data_o`, `wp_*` and `flags_o` after edge N.
- Stage 2 observes `rd3_o`/`stl3_o` in the same cycle, so back-to-back dependent ops forward with zero bubbles.
- Multiply latency is 33: accepted at edge N, result after edge N+32. `ready_o` is low after edge N through edge N+32 and high again in the cycle `valid_o` is asserted.
- `stl3_o` is low throughout MUL (no stale forwarding); `data_o` holds its previous value.
- `valid_i` while `ready_o` = 0: not accepted; the upstream must hold `data_i`.
- `cen` takes C as it was before the accepting edge, so back-to-back carry chains are correct.

## Configuration
- `HS32_MUL_EN` defined:
  - `mul_i` port, MUL state, 32-bit multiplicand/accumulator registers and counter are compiled in.
- `HS32_MUL_EN` undefined:
  - No `mul_i` port; the FSM reduces to IDLE.
  - `ready_o` is tied to 1 except during reset.

## Test plan
- Reset: hold `rstn` = 0 for 2 cycles with `valid_i` = 1 → `valid_o` = 0, `flags_o` = 0, `data_o.res` = 0, `wp_we_o` = 0.
- Subtract: `d1` = 5, `d2` = 5, `neg` = `sub` = 1, `opr` = 0, `fwe` = 1, `rd` = 3, `we1` = 1 → next cycle `res` = 0, flags Z = 1, C = 1, N = V = 0, `wp_we_o` = 1, `wp_addr_o` = 3, `stl3_o` = 1, `rd3_o` = 3.
- Carry chain: `d1` = 0xFFFFFFFF, `d2` = 1, add with `fwe` → `res` = 0, C = 1. Next cycle `d1` = 0, `d2` = 0, `cen` = 1 → `res` = 1.
- Overflow and logic:
  - 0x7FFFFFFF + 1 → `res` = 0x80000000, N = 1, V = 1.
  - BIC: `d1` = 0xFF, `d2` = 0x0F, `neg` = 1, `opr` = 1 → `res` = 0xF0, C and V unchanged.
- Multiply (macro on): `mul_i` with 0x10001 × 0x10001 → `ready_o` low for 32 cycles, `stl3_o` = 0 meanwhile; then `res` = 0x00020001, `valid_o` high for 1 cycle. An ALU op presented during MUL is accepted only after completion.
- Reset mid-multiply: assert `rstn` = 0 at cycle 10 of MUL → no result is ever emitted, `ready_o` = 1 after release, next ALU op completes in 1 cycle.
